// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked stores, one-cycle registered loads, and a
// word-by-word clear sequence after reset or on a DMEM_rst request.
module dmem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RD,
    input  logic        WR,
    input  logic [31:0] A_DMEM,
    input  logic [31:0] D_out,
    input  logic [3:0]  byte_mark,
    input  logic        DMEM_rst,
    output logic [31:0] D_in,
    output logic        busy,
    output logic        addr_err
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic [31:0]     r_d_in;
    logic [31:0]     w_d_in_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_addr_err;
    logic            w_addr_err_nxt;
    logic [31:0]     r_mem [DEPTH];

    logic [31:0]     w_offset;
    logic            w_in_range;
    logic [AW-1:0]   w_idx;
    logic            w_we;
    logic [AW-1:0]   w_widx;
    logic [31:0]     w_wdata;
    logic [3:0]      w_wbe;

    // Unsigned compare rejects addresses below BASE_ADDR too, since they wrap high.
    assign w_offset   = A_DMEM - BASE_ADDR;
    assign w_in_range = (w_offset < SPAN);
    assign w_idx      = w_offset[AW+1:2];

    // State, clear counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= {AW{1'b0}};
            r_d_in     <= 32'h0000_0000;
            r_busy     <= 1'b1;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_d_in     <= w_d_in_nxt;
            r_busy     <= w_busy_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    // Next-state and clear-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (DMEM_rst) begin
                    w_cnt_nxt = {AW{1'b0}};
                end else if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {AW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (DMEM_rst) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = {AW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = {AW{1'b0}};
            end
        endcase
    end

    // Memory write port, load data and error pulse for the current cycle.
    always_comb begin
        w_we           = 1'b0;
        w_widx         = r_cnt;
        w_wdata        = 32'h0000_0000;
        w_wbe          = 4'h0;
        w_d_in_nxt     = r_d_in;
        w_addr_err_nxt = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_d_in_nxt = 32'h0000_0000;
                if (!DMEM_rst) begin
                    w_we  = 1'b1;
                    w_wbe = 4'hF;
                end else begin
                    w_we = 1'b0;
                end
            end
            ST_IDLE: begin
                if (!DMEM_rst && (RD || WR)) begin
                    if (w_in_range) begin
                        if (WR) begin
                            w_we    = 1'b1;
                            w_widx  = w_idx;
                            w_wdata = D_out;
                            w_wbe   = byte_mark;
                        end else begin
                            w_we = 1'b0;
                        end
                        if (RD) begin
                            w_d_in_nxt = r_mem[w_idx];
                        end else begin
                            w_d_in_nxt = r_d_in;
                        end
                    end else begin
                        w_addr_err_nxt = 1'b1;
                        if (RD) begin
                            w_d_in_nxt = 32'h0000_0000;
                        end else begin
                            w_d_in_nxt = r_d_in;
                        end
                    end
                end else begin
                    w_we = 1'b0;
                end
            end
            default: begin
                w_d_in_nxt = 32'h0000_0000;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_CLEAR);
    end

    // Byte-lane array write; held off during reset so contents stay untouched.
    always_ff @(posedge clk) begin
        if (rst_n && w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wbe[i]) begin
                    r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign D_in     = r_d_in;
    assign busy     = r_busy;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected load/error
// results, a negedge monitor pops and compares them.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RD;
    logic        WR;
    logic [31:0] A_DMEM;
    logic [31:0] D_out;
    logic [3:0]  byte_mark;
    logic        DMEM_rst;
    logic [31:0] D_in;
    logic        busy;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          due;
        string       nm;
        logic [31:0] d;
        logic        err;
    } exp_t;
    exp_t q[$];

    dmem_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .RD(RD), .WR(WR), .A_DMEM(A_DMEM),
        .D_out(D_out), .byte_mark(byte_mark), .DMEM_rst(DMEM_rst),
        .D_in(D_in), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every result due this cycle; any unexpected addr_err is an error.
    always @(negedge clk) begin
        exp_t e;
        bit   seen;
        seen = 1'b0;
        if (mon_en) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                seen = 1'b1;
                n_checks++;
                if (e.due != cyc) begin
                    n_fail++;
                    $display("FAIL %s: result not sampled at cycle %0d (now %0d)", e.nm, e.due, cyc);
                end else if (D_in !== e.d || addr_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got D_in=%h addr_err=%b, expected D_in=%h addr_err=%b",
                             e.nm, D_in, addr_err, e.d, e.err);
                end
            end
            if (!seen && addr_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_addr_err: got addr_err=1 at cycle %0d, expected 0", cyc);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, got, got, exp, exp);
        end
    endtask

    // One clock of stimulus; optionally queue the result expected after this edge.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic drst, input logic chk, input string nm,
                        input logic [31:0] ed, input logic ee);
        exp_t e;
        RD = rd; WR = wr; A_DMEM = a; D_out = d; byte_mark = m; DMEM_rst = drst;
        if (chk) begin
            e.due = cyc + 1; e.nm = nm; e.d = ed; e.err = ee;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        RD = 1'b0; WR = 1'b0; A_DMEM = 32'h0; D_out = 32'h0; byte_mark = 4'h0; DMEM_rst = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] ed, input logic ee, input string nm);
        step(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, 1'b1, nm, ed, ee);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        step(1'b0, 1'b1, a, d, m, 1'b0, 1'b0, "", 32'h0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, "", 32'h0, 1'b0);
    endtask

    // Count cycles until busy drops, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            idle();
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; RD = 1'b0; WR = 1'b0; A_DMEM = 32'h0; D_out = 32'h0;
        byte_mark = 4'h0; DMEM_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'd1);
        check("rst_d_in", D_in, 32'h0);
        check("rst_addr_err", {31'h0, addr_err}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_idle(n);
        check("reset_busy_len", n, 32'd256);

        rd_chk(32'h000, 32'h0, 1'b0, "clr_rd_000");
        rd_chk(32'h200, 32'h0, 1'b0, "clr_rd_200");
        rd_chk(32'h3FC, 32'h0, 1'b0, "clr_rd_3fc");

        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd_chk(32'h10, 32'hDEADBEEF, 1'b0, "full_word");
        rd_chk(32'h10, 32'hDEADBEEF, 1'b0, "b2b_10_a");
        rd_chk(32'h14, 32'h00000000, 1'b0, "b2b_14");
        rd_chk(32'h10, 32'hDEADBEEF, 1'b0, "b2b_10_b");

        wr(32'h10, 32'h11223344, 4'b0101);
        rd_chk(32'h10, 32'hDE22BE44, 1'b0, "mask_0101");
        wr(32'h10, 32'hFFFFFFFF, 4'b0000);
        rd_chk(32'h10, 32'hDE22BE44, 1'b0, "mask_0000");

        step(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, "rdwr_old", 32'h0, 1'b0);
        rd_chk(32'h20, 32'hCAFEF00D, 1'b0, "rdwr_new");

        wr(32'h3FC, 32'h12345678, 4'hF);
        rd_chk(32'h3FC, 32'h12345678, 1'b0, "top_word");
        step(1'b0, 1'b1, 32'h400, 32'hAAAAAAAA, 4'hF, 1'b0, 1'b1, "oor_wr", 32'h12345678, 1'b1);
        rd_chk(32'h400, 32'h0, 1'b1, "oor_rd");
        rd_chk(32'hFFFF_FFFC, 32'h0, 1'b1, "oor_rd_high");
        rd_chk(32'h000, 32'h0, 1'b0, "no_wrap_word0");

        // A request in the DMEM_rst cycle is ignored: D_in holds, the store is dropped.
        wr(32'h40, 32'h00000055, 4'hF);
        rd_chk(32'h40, 32'h00000055, 1'b0, "pre_clear_40");
        step(1'b1, 1'b1, 32'h10, 32'h00000077, 4'hF, 1'b1, 1'b1, "drst_cycle_hold", 32'h00000055, 1'b0);
        rd_chk(32'h10, 32'h0, 1'b0, "rd_during_busy");
        step(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 1'b1, "oor_during_busy", 32'h0, 1'b0);
        repeat (98) idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, "", 32'h0, 1'b0);
        wait_idle(n);
        check("restart_busy_len", n, 32'd256);

        for (int i = 0; i < 256; i++) begin
            rd_chk(32'(i * 4), 32'h0, 1'b0, "cleared_word");
        end
        idle();
        idle();

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending results, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
